// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: opcode table, error codes and decoder state encoding for spi_cmd_decoder.
package spi_cmd_pkg;

    typedef enum logic [1:0] {IDLE, PAYLOAD, DISCARD} state_t;

    localparam logic [7:0] OP_SET_MODE       = 8'h01;
    localparam logic [7:0] OP_SET_OFFSET     = 8'h02;
    localparam logic [7:0] OP_SET_CHROMA     = 8'h03;
    localparam logic [7:0] OP_SET_ALPHA      = 8'h04;
    localparam logic [7:0] OP_RESET_SETTINGS = 8'h05;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_UNKNOWN = 2'b01;
    localparam logic [1:0] ERR_TRUNC   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    function automatic logic op_known(input logic [7:0] op);
        return op inside {OP_SET_MODE, OP_SET_OFFSET, OP_SET_CHROMA, OP_SET_ALPHA, OP_RESET_SETTINGS};
    endfunction

    function automatic logic [2:0] op_len(input logic [7:0] op);
        return op == OP_SET_MODE   ? 3'd1 :
               op == OP_SET_OFFSET ? 3'd4 :
               op == OP_SET_CHROMA ? 3'd2 :
               op == OP_SET_ALPHA  ? 3'd1 : 3'd0;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with a configurable reset value for asynchronous inputs.
module sync_2ff #(
    parameter int WIDTH = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: frames SPI bytes into opcode+payload commands and reports
// unknown-opcode, truncation and timeout errors.
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int ARG_BYTES      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hw_spi_ss,
    input  logic [7:0]             byte_in,
    input  logic                   byte_valid,
    output logic                   cmd_valid,
    output logic [7:0]             cmd_opcode,
    output logic [8*ARG_BYTES-1:0] cmd_arg,
    output logic                   err_valid,
    output logic [1:0]             err_code,
    output logic [7:0]             err_count
);

    localparam int W  = 8 * ARG_BYTES;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t         state, state_n;
    logic [7:0]     op, op_n;
    logic [W-1:0]   arg, arg_n, arg_shift;
    logic [2:0]     rem, rem_n;
    logic [TW-1:0]  tcnt, tcnt_n;
    logic           cmd_valid_n, err_valid_n;
    logic [7:0]     cmd_opcode_n;
    logic [W-1:0]   cmd_arg_n;
    logic [1:0]     err_code_n;
    logic           ss_s, ss_d, ss_rise;

    sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_ss_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (hw_spi_ss),
        .q     (ss_s)
    );

    assign ss_rise   = ss_s & ~ss_d;
    assign arg_shift = {arg[W-9:0], byte_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op         <= '0;
            arg        <= '0;
            rem        <= '0;
            tcnt       <= '0;
            ss_d       <= 1'b1;
            cmd_valid  <= 1'b0;
            cmd_opcode <= '0;
            cmd_arg    <= '0;
            err_valid  <= 1'b0;
            err_code   <= ERR_NONE;
            err_count  <= '0;
        end else begin
            state      <= state_n;
            op         <= op_n;
            arg        <= arg_n;
            rem        <= rem_n;
            tcnt       <= tcnt_n;
            ss_d       <= ss_s;
            cmd_valid  <= cmd_valid_n;
            cmd_opcode <= cmd_opcode_n;
            cmd_arg    <= cmd_arg_n;
            err_valid  <= err_valid_n;
            err_code   <= err_code_n;
            if (err_valid_n && err_count != 8'hff)
                err_count <= err_count + 8'd1;
        end
    end

    // A byte arriving with ss_rise is consumed first; only an incomplete command is truncated.
    always_comb begin
        state_n      = state;
        op_n         = op;
        arg_n        = arg;
        rem_n        = rem;
        tcnt_n       = '0;
        cmd_valid_n  = 1'b0;
        cmd_opcode_n = cmd_opcode;
        cmd_arg_n    = cmd_arg;
        err_valid_n  = 1'b0;
        err_code_n   = err_code;
        case (state)
            IDLE: begin
                if (byte_valid && op_known(byte_in)) begin
                    op_n  = byte_in;
                    arg_n = '0;
                    rem_n = op_len(byte_in);
                    if (op_len(byte_in) == 3'd0) begin
                        cmd_valid_n  = 1'b1;
                        cmd_opcode_n = byte_in;
                        cmd_arg_n    = '0;
                    end else begin
                        state_n = PAYLOAD;
                    end
                end else if (byte_valid) begin
                    err_valid_n = 1'b1;
                    err_code_n  = ERR_UNKNOWN;
                    state_n     = DISCARD;
                end
            end
            PAYLOAD: begin
                if (byte_valid && rem == 3'd1) begin
                    rem_n        = '0;
                    arg_n        = arg_shift;
                    cmd_valid_n  = 1'b1;
                    cmd_opcode_n = op;
                    cmd_arg_n    = arg_shift;
                    state_n      = IDLE;
                end else if (ss_rise) begin
                    err_valid_n = 1'b1;
                    err_code_n  = ERR_TRUNC;
                    state_n     = IDLE;
                end else if (byte_valid) begin
                    rem_n = rem - 3'd1;
                    arg_n = arg_shift;
                end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_valid_n = 1'b1;
                    err_code_n  = ERR_TIMEOUT;
                    state_n     = DISCARD;
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            DISCARD: state_n = ss_rise ? IDLE : DISCARD;
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb_spi_cmd_decoder: table-driven frames plus hand-written timeout, saturation and reset sequences.
module tb_spi_cmd_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hw_spi_ss = 1'b1;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        cmd_valid;
    logic [7:0]  cmd_opcode;
    logic [31:0] cmd_arg;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [7:0]  err_count;

    int total = 0, bad = 0;
    int n_cmd = 0, n_err = 0, n_both = 0;

    spi_cmd_decoder #(.TIMEOUT_CYCLES(16), .ARG_BYTES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hw_spi_ss  (hw_spi_ss),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .cmd_valid  (cmd_valid),
        .cmd_opcode (cmd_opcode),
        .cmd_arg    (cmd_arg),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cmd_valid) n_cmd++;
        if (err_valid) n_err++;
        if (cmd_valid && err_valid) n_both++;
    end

    typedef struct {
        logic [39:0] bytes;
        int          n;
        int          cmds;
        int          errs;
        logic        last_cv;
        logic [7:0]  op;
        logic [31:0] arg;
        logic [1:0]  code;
    } vec_t;

    vec_t v[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        byte_in = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic ss_lo();
        @(negedge clk);
        hw_spi_ss = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic ss_hi();
        @(negedge clk);
        hw_spi_ss = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int c0, e0, w;
        logic lcv;
        v[0] = '{40'h0200100020, 5, 1, 0, 1'b1, 8'h02, 32'h00100020, 2'b00};
        v[1] = '{40'h015A000000, 2, 1, 0, 1'b1, 8'h01, 32'h0000005A, 2'b00};
        v[2] = '{40'h0312340000, 3, 1, 0, 1'b1, 8'h03, 32'h00001234, 2'b00};
        v[3] = '{40'h047F000000, 2, 1, 0, 1'b1, 8'h04, 32'h0000007F, 2'b00};
        v[4] = '{40'h0500000000, 1, 1, 0, 1'b1, 8'h05, 32'h00000000, 2'b00};
        v[5] = '{40'h05047F0000, 3, 2, 0, 1'b1, 8'h04, 32'h0000007F, 2'b00};
        v[6] = '{40'hAA01020000, 3, 0, 1, 1'b0, 8'h04, 32'h0000007F, 2'b01};
        v[7] = '{40'h0103000000, 2, 1, 0, 1'b1, 8'h01, 32'h00000003, 2'b01};
        v[8] = '{40'h0312000000, 2, 0, 1, 1'b0, 8'h01, 32'h00000003, 2'b10};
        v[9] = '{40'h0000000000, 1, 0, 1, 1'b0, 8'h01, 32'h00000003, 2'b01};

        repeat (3) @(negedge clk);
        chk("reset_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("reset_err_valid", 32'(err_valid), 32'd0);
        chk("reset_opcode", 32'(cmd_opcode), 32'd0);
        chk("reset_arg", cmd_arg, 32'd0);
        chk("reset_err_code", 32'(err_code), 32'd0);
        chk("reset_err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            c0 = n_cmd;
            e0 = n_err;
            ss_lo();
            for (int k = 0; k < v[i].n; k++) send(v[i].bytes[39-8*k -: 8]);
            lcv = cmd_valid;
            ss_hi();
            chk($sformatf("v%0d_last_cmd_valid", i), 32'(lcv), 32'(v[i].last_cv));
            chk($sformatf("v%0d_cmd_pulses", i), 32'(n_cmd - c0), 32'(v[i].cmds));
            chk($sformatf("v%0d_err_pulses", i), 32'(n_err - e0), 32'(v[i].errs));
            chk($sformatf("v%0d_opcode", i), 32'(cmd_opcode), 32'(v[i].op));
            chk($sformatf("v%0d_arg", i), cmd_arg, v[i].arg);
            chk($sformatf("v%0d_err_code", i), 32'(err_code), 32'(v[i].code));
        end
        chk("table_err_count", 32'(err_count), 32'd3);

        // timeout: 16 idle cycles after a payload byte, then bytes are discarded until ss_rise
        c0 = n_cmd;
        e0 = n_err;
        ss_lo();
        send(8'h02);
        send(8'h00);
        w = 0;
        while (!err_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("timeout_wait", 32'(w), 32'd16);
        chk("timeout_code", 32'(err_code), 32'd3);
        send(8'h01);
        send(8'h03);
        chk("discard_no_cmd", 32'(n_cmd - c0), 32'd0);
        chk("discard_one_err", 32'(n_err - e0), 32'd1);
        ss_hi();
        ss_lo();
        send(8'h04);
        send(8'h55);
        ss_hi();
        chk("after_timeout_opcode", 32'(cmd_opcode), 32'h04);
        chk("after_timeout_arg", cmd_arg, 32'h55);
        chk("after_timeout_err_count", 32'(err_count), 32'd4);

        e0 = n_err;
        for (int i = 0; i < 300; i++) begin
            ss_lo();
            send(8'hFF);
            ss_hi();
        end
        chk("sat_err_pulses", 32'(n_err - e0), 32'd300);
        chk("sat_err_count", 32'(err_count), 32'hFF);

        // async reset in the middle of a SET_OFFSET payload
        ss_lo();
        send(8'h02);
        send(8'h11);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_err_count", 32'(err_count), 32'd0);
        chk("arst_opcode", 32'(cmd_opcode), 32'd0);
        chk("arst_arg", cmd_arg, 32'd0);
        chk("arst_err_code", 32'(err_code), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        c0 = n_cmd;
        e0 = n_err;
        repeat (25) @(negedge clk);
        chk("arst_no_cmd", 32'(n_cmd - c0), 32'd0);
        chk("arst_no_err", 32'(n_err - e0), 32'd0);
        ss_hi();
        chk("arst_ss_rise_no_err", 32'(n_err - e0), 32'd0);
        ss_lo();
        send(8'h03);
        send(8'hAB);
        send(8'hCD);
        ss_hi();
        chk("post_reset_opcode", 32'(cmd_opcode), 32'h03);
        chk("post_reset_arg", cmd_arg, 32'h0000ABCD);
        chk("post_reset_cmds", 32'(n_cmd - c0), 32'd1);
        chk("never_both_pulses", 32'(n_both), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
Downstream of the SPI slave byte receiver. It consumes the received byte stream and frames it into commands of the form opcode byte plus a fixed-length payload. Each complete command is presented as one registered opcode/argument pulse to the overlay settings registers. It flags unknown opcodes, frames truncated by slave-select deassertion, and stalled transfers.

Parameters:
TIMEOUT_CYCLES, 65535, clk cycles allowed between payload bytes before the command is abandoned; counter width is $clog2(TIMEOUT_CYCLES+1).
ARG_BYTES, 4, maximum payload length in bytes; cmd_arg width is 8*ARG_BYTES.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst_n  in  1  asynchronous active-low reset.
hw_spi_ss  in  1  raw SPI slave select, active-low, asynchronous to clk.
byte_in  in  8  received byte from the SPI slave.
byte_valid  in  1  one-cycle strobe; byte_in is valid this cycle.
cmd_valid  out  1  one-cycle pulse; a complete command is on cmd_opcode/cmd_arg.
cmd_opcode  out  8  opcode of the last completed command.
cmd_arg  out  8*ARG_BYTES  payload, right-aligned, first byte most significant.
err_valid  out  1  one-cycle pulse on a framing or protocol error.
err_code  out  2  01 unknown opcode, 10 truncated, 11 timeout; holds until the next err_valid.
err_count  out  8  saturating count of errors since reset.

Behaviour:
- Reset (async, rst_n=0): state IDLE; cmd_valid=0, err_valid=0, cmd_opcode=0, cmd_arg=0, err_code=0, err_count=0, ss sync flops=1 (inactive), timeout counter=0.
- hw_spi_ss passes through a 2-flop synchronizer. ss_rise is the synchronized 0->1 transition, one cycle wide.
- Opcode table: 0x01 SET_MODE=1B, 0x02 SET_OFFSET=4B (x16,y16), 0x03 SET_CHROMA=2B, 0x04 SET_ALPHA=1B, 0x05 RESET_SETTINGS=0B. Every other value is unknown.
- State IDLE:
  - byte_valid with a known opcode: latch the opcode, clear the assembly register, and load remaining = length.
  - If length=0, pulse cmd_valid next cycle and stay in IDLE. Otherwise go to PAYLOAD.
  - byte_valid with an unknown opcode: pulse err_valid with code 01 next cycle, then go to DISCARD.
  - ss_rise in IDLE: no effect.
- State PAYLOAD:
  - Each byte_valid shifts arg={arg[8*ARG_BYTES-9:0], byte_in}, decrements remaining and clears the timeout counter.
  - On the last byte: register cmd_opcode/cmd_arg and pulse cmd_valid the following cycle (latency 1 clk from the final byte_valid), then return to IDLE.
  - ss_rise with remaining>0: err code 10, go to IDLE, cmd_valid not asserted.
  - Timeout counter reaches TIMEOUT_CYCLES without a byte: err code 11, go to DISCARD.
- State DISCARD: ignore all bytes. Go to IDLE on ss_rise. Further errors are not reported.
- Multiple commands per ss-low frame are legal: IDLE re-arms immediately after each command.
- Simultaneous byte_valid and ss_rise: the byte is processed first.
  - If it completes the command, cmd_valid is asserted and no error is raised.
  - If it does not complete the command, the truncation error is raised and the partial command is dropped.
- cmd_opcode/cmd_arg change only when cmd_valid is asserted and are stable otherwise.
- cmd_valid and err_valid are never asserted in the same cycle.
- err_count increments on each err_valid and saturates at 0xFF.
- rst_n asserted mid-command drops all partial state; no pulses are emitted afterwards.

Decomposition:
- Shared package/header spi_cmd_pkg:
  - opcode constants
  - opcode-to-length function
  - error code constants
  - state encoding (IDLE, PAYLOAD, DISCARD)
- Sub-module sync_2ff (parameterised reset value) for hw_spi_ss; it is reusable by other clock-domain inputs in the design.

Test Plan:
- SET_OFFSET: bytes 02 00 10 00 20 with ss low -> a single cmd_valid 1 clk after the 5th byte; cmd_opcode=0x02, cmd_arg=0x00100020; err_valid never asserted.
- Back-to-back in one frame: 05 then 04 7F -> cmd_valid for 0x05 with arg=0, then cmd_valid for 0x04 with arg=0x0000007F.
- Unknown opcode: AA 01 02, then ss high, then 01 03 -> err_code=01 and err_count=1; the bytes 01 02 produce no cmd_valid; after ss_rise, 01 03 gives cmd_opcode=0x01, arg=0x03.
- Truncation: 03 12 then ss deassert -> err_code=10; cmd_opcode/cmd_arg keep their prior values.
- Timeout with TIMEOUT_CYCLES=16: 02 00, then idle for 16 cycles -> err_code=11 and state DISCARD; subsequent bytes are ignored until ss_rise.
- Async reset mid-PAYLOAD, and 300 errors in sequence -> after reset all outputs are 0 and no stray pulses occur; err_count saturates at 0xFF.
